// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states, M-extension funct7.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] F7_MULDIV_DEFAULT = 7'b0000001;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational funct7/funct3 decode: op, operand signedness, high-half select, legality.
// Zero latency; no flow control of its own.
module muldiv_decode
    import muldiv_pkg::*;
#(
    parameter logic [6:0] F7_MULDIV = F7_MULDIV_DEFAULT
) (
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output muldiv_op_e op,
    output logic       rs1_signed,
    output logic       rs2_signed,
    output logic       hi_sel,
    output logic       is_div,
    output logic       legal
);

    always_comb begin
        op         = muldiv_op_e'(funct3);
        legal      = (funct7 == F7_MULDIV);
        is_div     = funct3[2];
        hi_sel     = 1'b0;
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        case (op)
            OP_MULH:   begin hi_sel = 1'b1; rs1_signed = 1'b1; rs2_signed = 1'b1; end
            OP_MULHSU: begin hi_sel = 1'b1; rs1_signed = 1'b1; end
            OP_MULHU:  hi_sel = 1'b1;
            OP_DIV,
            OP_REM:    begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension unit: magnitude shift-add multiply / restoring divide, sign fixed at the end.
// Fixed latency XLEN+1 cycles from acceptance to o_done; accepts only while o_ready (IDLE).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter logic [6:0] F7_MULDIV = F7_MULDIV_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [6:0]      i_Funct7,
    input  logic [2:0]      i_Funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_ready,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal
);

    localparam int CW = $clog2(XLEN) + 1;

    muldiv_state_e   state, state_nxt;
    logic [CW-1:0]   cnt;
    muldiv_op_e      op_q;
    logic            hi_q, div_q, s1neg_q, s2neg_q, dz_q;
    logic [XLEN-1:0] mcand_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0] result_q;

    muldiv_op_e dec_op;
    logic       dec_s1, dec_s2, dec_hi, dec_div, dec_legal;

    muldiv_decode #(.F7_MULDIV(F7_MULDIV)) u_decode (
        .funct7     (i_Funct7),
        .funct3     (i_Funct3),
        .op         (dec_op),
        .rs1_signed (dec_s1),
        .rs2_signed (dec_s2),
        .hi_sel     (dec_hi),
        .is_div     (dec_div),
        .legal      (dec_legal)
    );

    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_mag, rs2_mag;
    logic            accept, step, finish;

    assign rs1_neg = dec_s1 & i_rs1[XLEN-1];
    assign rs2_neg = dec_s2 & i_rs2[XLEN-1];
    assign rs1_mag = rs1_neg ? -i_rs1 : i_rs1;
    assign rs2_mag = rs2_neg ? -i_rs2 : i_rs2;

    assign accept = (state == ST_IDLE) & i_valid & dec_legal & ~i_flush;
    assign step   = (state == ST_CALC) & ~i_flush & (cnt != CW'(XLEN));
    assign finish = (state == ST_CALC) & ~i_flush & (cnt == CW'(XLEN));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_CALC;
            ST_CALC: begin
                if (i_flush)     state_nxt = ST_IDLE;
                else if (finish) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
        if (div_q)
            acc_step = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                                : {1'b0, acc_q[2*XLEN-1:1]};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_final;
    logic              q_neg;

    // A zero divisor keeps the raw all-ones quotient regardless of dividend sign
    always_comb begin
        prod      = (s1neg_q ^ s2neg_q) ? -acc_q : acc_q;
        q_neg     = (s1neg_q ^ s2neg_q) & ~dz_q;
        quo_fix   = q_neg   ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
        rem_fix   = s1neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (div_q)
            res_final = (op_q == OP_REM || op_q == OP_REMU) ? rem_fix : quo_fix;
        else
            res_final = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            op_q     <= OP_MUL;
            hi_q     <= 1'b0;
            div_q    <= 1'b0;
            s1neg_q  <= 1'b0;
            s2neg_q  <= 1'b0;
            dz_q     <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                cnt     <= '0;
                op_q    <= dec_op;
                hi_q    <= dec_hi;
                div_q   <= dec_div;
                s1neg_q <= rs1_neg;
                s2neg_q <= rs2_neg;
                dz_q    <= (i_rs2 == '0);
                mcand_q <= rs2_mag;
                acc_q   <= {{XLEN{1'b0}}, rs1_mag};
            end else if (step) begin
                cnt   <= cnt + CW'(1);
                acc_q <= acc_step;
            end
            if (finish) result_q <= res_final;
        end
    end

    assign o_ready   = (state == ST_IDLE);
    assign o_done    = (state == ST_DONE);
    assign o_result  = result_q;
    assign o_illegal = i_valid & o_ready & (i_Funct7 != F7_MULDIV);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random + directed bench for muldiv_unit with a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic [6:0]  i_Funct7;
    logic [2:0]  i_Funct3;
    logic [31:0] i_rs1, i_rs2;
    logic        i_flush;
    logic        o_ready, o_done, o_illegal;
    logic [31:0] o_result;

    muldiv_unit #(.XLEN(32), .F7_MULDIV(7'b0000001)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .i_Funct7  (i_Funct7),
        .i_Funct3  (i_Funct3),
        .i_rs1     (i_rs1),
        .i_rs2     (i_rs2),
        .i_flush   (i_flush),
        .o_ready   (o_ready),
        .o_done    (o_done),
        .o_result  (o_result),
        .o_illegal (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int next_id = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
        int          id;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int sa, sd;
        sa = a;
        sd = b;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return sa / sd;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sd;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Pops an expectation on every o_done; an unexpected done is itself a failure
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && o_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: o_done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("result#%0d", e.id), o_result, e.res);
                check($sformatf("done_cycle#%0d", e.id), 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: o_ready=%b after %0d cycles, required 1", o_ready, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Drives one request; operands are scrambled right after acceptance
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit exp_done, input logic [31:0] expv, output int e0);
        @(negedge i_clk);
        wait_ready();
        i_valid  = 1'b1;
        i_Funct7 = 7'h01;
        i_Funct3 = f3;
        i_rs1    = a;
        i_rs2    = b;
        @(posedge i_clk);
        #1;
        e0       = cyc;
        i_valid  = 1'b0;
        i_Funct3 = 3'($urandom_range(0, 7));
        i_rs1    = $urandom;
        i_rs2    = $urandom;
        if (exp_done) begin
            sb.push_back('{expv, e0 + 33, next_id});
            next_id++;
        end
    endtask

    logic [2:0]  d_f3[10]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a[10]   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[10]   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp[10] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [2:0]  f3;
        logic [31:0] a, b;

        i_rst = 1'b1; i_valid = 1'b0; i_Funct7 = 7'h01; i_Funct3 = 3'd0;
        i_rs1 = '0; i_rs2 = '0; i_flush = 1'b0;
        #2;
        check("reset_ready",  32'(o_ready),  32'd1);
        check("reset_done",   32'(o_done),   32'd0);
        check("reset_result", o_result,      32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        // Directed vectors with known answers
        issue(d_f3[0], d_a[0], d_b[0], 1'b1, d_exp[0], e0);
        drain();
        repeat (3) @(negedge i_clk);
        check("result_hold", o_result, 32'hFFFF_FFEB);
        for (int i = 1; i < 10; i++)
            issue(d_f3[i], d_a[i], d_b[i], 1'b1, d_exp[i], e0);
        drain();

        // Flush mid-CALC: no done, back to IDLE after the flush edge
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'h0, e0);
        while (cyc < e0 + 9) @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        check("flush_ready", 32'(o_ready), 32'd1);
        repeat (40) @(negedge i_clk);

        // i_valid pulses during CALC are ignored
        issue(3'd5, 32'd1000, 32'd7, 1'b1, 32'd142, e0);
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_valid = 1'b1; i_Funct7 = 7'h01; i_Funct3 = 3'd0;
            i_rs1 = $urandom; i_rs2 = $urandom;
        end
        check("calc_not_ready", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        drain();

        // Illegal funct7: flagged, not accepted
        @(negedge i_clk);
        wait_ready();
        i_valid = 1'b1; i_Funct7 = 7'h20; i_Funct3 = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd4;
        #1;
        check("illegal_flag", 32'(o_illegal), 32'd1);
        @(posedge i_clk);
        #1;
        check("illegal_stays_idle", 32'(o_ready), 32'd1);
        // Flush together with a legal request in IDLE: flush wins
        i_Funct7 = 7'h01;
        i_flush  = 1'b1;
        #1;
        check("legal_not_illegal", 32'(o_illegal), 32'd0);
        @(posedge i_clk);
        #1;
        check("flush_beats_valid", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        i_flush = 1'b0;
        repeat (40) @(negedge i_clk);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            issue(f3, a, b, 1'b1, ref_model(f3, a, b), e0);
        end
        drain();

        // Asynchronous reset mid-CALC, then a fresh MULHU
        issue(3'd0, 32'd3, 32'd5, 1'b1, 32'd15, e0);
        drain();
        issue(3'd4, 32'h7777_0000, 32'd3, 1'b0, 32'h0, e0);
        repeat (15) @(posedge i_clk);
        #3;
        i_rst = 1'b1;
        #1;
        check("arst_ready",  32'(o_ready), 32'd1);
        check("arst_done",   32'(o_done),  32'd0);
        check("arst_result", o_result,     32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), e0);
        drain();
        repeat (5) @(negedge i_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
